// File: rtl/v_lsu_ctrl.sv
// Vector load/store sequencer: splits one whole-register unit-stride command into VLEN-wide beats between v_mem and the VRF.
// Latency: 2*nreg+1 cycles from the cycle after acceptance up to and including the done_o pulse.
// Backpressure: req_ready_o is high only in IDLE; one command in flight, request inputs ignored while busy.
module v_lsu_ctrl #(
   parameter int VLEN    = 256,
   parameter int VADDR_W = 64,
   parameter int VIDX_W  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_is_load_i,
   input  logic [VADDR_W-1:0] req_addr_i,
   input  logic [VIDX_W-1:0]  req_vreg_i,
   input  logic [3:0]         req_nreg_i,
   output logic               done_o,
   output logic               busy_o,
   output logic               vmem_r_ena_o,
   output logic [VADDR_W-1:0] vmem_r_addr_o,
   input  logic [VLEN-1:0]    vmem_r_data_i,
   output logic               vmem_w_ena_o,
   output logic [VADDR_W-1:0] vmem_w_addr_o,
   output logic [VLEN-1:0]    vmem_w_data_o,
   output logic               vrf_r_ena_o,
   output logic [VIDX_W-1:0]  vrf_r_idx_o,
   input  logic [VLEN-1:0]    vrf_r_data_i,
   output logic               vrf_w_ena_o,
   output logic [VIDX_W-1:0]  vrf_w_idx_o,
   output logic [VLEN-1:0]    vrf_w_data_o
);

   localparam int BEAT_BYTES = VLEN / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_REQ,
      S_LD_WB,
      S_ST_RD,
      S_ST_WR,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         beat_q, beat_d;
   logic [2:0]         last_q;
   logic [VADDR_W-1:0] addr_q;
   logic [VIDX_W-1:0]  vreg_q;
   logic               accept;
   logic [VADDR_W-1:0] beat_addr;
   logic [VIDX_W-1:0]  beat_idx;

   assign accept = (state_q == S_IDLE) && req_valid_i;

   // Both sums wrap naturally at their own width (address space and 32-entry register file).
   assign beat_addr = addr_q + VADDR_W'(beat_q) * VADDR_W'(BEAT_BYTES);
   assign beat_idx  = vreg_q + VIDX_W'(beat_q);

   // State, beat counter and latched command; an out-of-range group size collapses to one beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         vreg_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (accept) begin
            addr_q <= req_addr_i;
            vreg_q <= req_vreg_i;
            if (req_nreg_i == 4'd0 || req_nreg_i > 4'd8) begin
               last_q <= 3'd0;
            end else begin
               last_q <= 3'(req_nreg_i - 4'd1);
            end
         end
      end
   end

   // Next state and all port outputs; every address/index/data output is zero outside its enable.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      req_ready_o   = 1'b0;
      busy_o        = 1'b1;
      done_o        = 1'b0;
      vmem_r_ena_o  = 1'b0;
      vmem_r_addr_o = '0;
      vmem_w_ena_o  = 1'b0;
      vmem_w_addr_o = '0;
      vmem_w_data_o = '0;
      vrf_r_ena_o   = 1'b0;
      vrf_r_idx_o   = '0;
      vrf_w_ena_o   = 1'b0;
      vrf_w_idx_o   = '0;
      vrf_w_data_o  = '0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (req_valid_i) begin
               beat_d  = '0;
               state_d = req_is_load_i ? S_LD_REQ : S_ST_RD;
            end
         end
         S_LD_REQ: begin
            vmem_r_ena_o  = 1'b1;
            vmem_r_addr_o = beat_addr;
            state_d       = S_LD_WB;
         end
         S_LD_WB: begin
            vrf_w_ena_o  = 1'b1;
            vrf_w_idx_o  = beat_idx;
            vrf_w_data_o = vmem_r_data_i;
            if (beat_q == last_q) begin
               state_d = S_DONE;
            end else begin
               beat_d  = beat_q + 3'd1;
               state_d = S_LD_REQ;
            end
         end
         S_ST_RD: begin
            vrf_r_ena_o = 1'b1;
            vrf_r_idx_o = beat_idx;
            state_d     = S_ST_WR;
         end
         S_ST_WR: begin
            vmem_w_ena_o  = 1'b1;
            vmem_w_addr_o = beat_addr;
            vmem_w_data_o = vrf_r_data_i;
            if (beat_q == last_q) begin
               state_d = S_DONE;
            end else begin
               beat_d  = beat_q + 3'd1;
               state_d = S_ST_RD;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            beat_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_v_lsu_ctrl.sv
// Bench for v_lsu_ctrl: directed scenarios followed by randomized commands.
// Every cycle all outputs are compared against a beat-schedule model of the command in flight.
// VRAM and VRF are modelled as arrays that also answer the DUT's read requests.
module tb_v_lsu_ctrl;
   localparam int VLEN    = 256;
   localparam int VADDR_W = 64;
   localparam int VIDX_W  = 5;

   logic               clk;
   logic               rst;
   logic               req_valid_i;
   logic               req_ready_o;
   logic               req_is_load_i;
   logic [VADDR_W-1:0] req_addr_i;
   logic [VIDX_W-1:0]  req_vreg_i;
   logic [3:0]         req_nreg_i;
   logic               done_o;
   logic               busy_o;
   logic               vmem_r_ena_o;
   logic [VADDR_W-1:0] vmem_r_addr_o;
   logic [VLEN-1:0]    vmem_r_data_i;
   logic               vmem_w_ena_o;
   logic [VADDR_W-1:0] vmem_w_addr_o;
   logic [VLEN-1:0]    vmem_w_data_o;
   logic               vrf_r_ena_o;
   logic [VIDX_W-1:0]  vrf_r_idx_o;
   logic [VLEN-1:0]    vrf_r_data_i;
   logic               vrf_w_ena_o;
   logic [VIDX_W-1:0]  vrf_w_idx_o;
   logic [VLEN-1:0]    vrf_w_data_o;

   v_lsu_ctrl #(.VLEN(VLEN), .VADDR_W(VADDR_W), .VIDX_W(VIDX_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_is_load_i(req_is_load_i), .req_addr_i(req_addr_i),
      .req_vreg_i(req_vreg_i), .req_nreg_i(req_nreg_i),
      .done_o(done_o), .busy_o(busy_o),
      .vmem_r_ena_o(vmem_r_ena_o), .vmem_r_addr_o(vmem_r_addr_o), .vmem_r_data_i(vmem_r_data_i),
      .vmem_w_ena_o(vmem_w_ena_o), .vmem_w_addr_o(vmem_w_addr_o), .vmem_w_data_o(vmem_w_data_o),
      .vrf_r_ena_o(vrf_r_ena_o), .vrf_r_idx_o(vrf_r_idx_o), .vrf_r_data_i(vrf_r_data_i),
      .vrf_w_ena_o(vrf_w_ena_o), .vrf_w_idx_o(vrf_w_idx_o), .vrf_w_data_o(vrf_w_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Memory models
   logic [VLEN-1:0] vram [logic [63:0]];
   logic [VLEN-1:0] vrf  [32];

   // Command model: a command of n beats occupies cycles 1..2n+1 after acceptance;
   // beat b requests in cycle 2b+1, transfers in 2b+2, done pulse in 2n+1.
   bit              m_busy = 0;
   bit              acc_flag = 0;
   int              m_t = 0;
   int              m_n = 1;
   bit              m_load = 0;
   logic [63:0]     m_addr = '0;
   logic [4:0]      m_vreg = '0;

   function automatic logic [VLEN-1:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [VLEN-1:0] vram_rd(input logic [63:0] a);
      if (vram.exists(a)) return vram[a];
      return {a, ~a, a ^ 64'hA5A5_5A5A_0F0F_F0F0, 32'h0, a[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: advance the model over the edge just taken, check every output, answer reads.
   task automatic step();
      logic            e_ready, e_busy, e_done;
      logic            e_rena, e_wena, e_vrena, e_vwena;
      logic [63:0]     e_raddr, e_waddr, a;
      logic [4:0]      e_vridx, e_vwidx, ix;
      logic [VLEN-1:0] e_wdata, e_vwdata;
      int              b;
      @(negedge clk);
      acc_flag = 0;
      if (!rst) begin
         m_busy = 0;
      end else if (m_busy) begin
         if (m_t == 2 * m_n + 1) m_busy = 0;
         else m_t++;
      end else if (req_valid_i) begin
         m_load = req_is_load_i;
         m_addr = req_addr_i;
         m_vreg = req_vreg_i;
         m_n    = (req_nreg_i >= 4'd1 && req_nreg_i <= 4'd8) ? int'(req_nreg_i) : 1;
         m_busy = 1;
         m_t    = 1;
         acc_flag = 1;
      end

      e_ready = !m_busy; e_busy = m_busy; e_done = 0;
      e_rena = 0; e_wena = 0; e_vrena = 0; e_vwena = 0;
      e_raddr = '0; e_waddr = '0; e_vridx = '0; e_vwidx = '0;
      e_wdata = '0; e_vwdata = '0;
      if (m_busy) begin
         if (m_t == 2 * m_n + 1) begin
            e_done = 1;
         end else begin
            b  = (m_t - 1) / 2;
            a  = m_addr + 64'(b) * 64'd32;
            ix = m_vreg + 5'(b);
            if ((m_t - 1) % 2 == 0) begin
               if (m_load) begin e_rena = 1; e_raddr = a; end
               else begin e_vrena = 1; e_vridx = ix; end
            end else if (m_load) begin
               e_vwena = 1; e_vwidx = ix; e_vwdata = vram_rd(a);
            end else begin
               e_wena = 1; e_waddr = a; e_wdata = vrf[ix];
            end
         end
      end

      chk("req_ready",   256'(req_ready_o),   256'(e_ready));
      chk("busy",        256'(busy_o),        256'(e_busy));
      chk("done",        256'(done_o),        256'(e_done));
      chk("vmem_r_ena",  256'(vmem_r_ena_o),  256'(e_rena));
      chk("vmem_r_addr", 256'(vmem_r_addr_o), 256'(e_raddr));
      chk("vmem_w_ena",  256'(vmem_w_ena_o),  256'(e_wena));
      chk("vmem_w_addr", 256'(vmem_w_addr_o), 256'(e_waddr));
      chk("vmem_w_data", vmem_w_data_o,       e_wdata);
      chk("vrf_r_ena",   256'(vrf_r_ena_o),   256'(e_vrena));
      chk("vrf_r_idx",   256'(vrf_r_idx_o),   256'(e_vridx));
      chk("vrf_w_ena",   256'(vrf_w_ena_o),   256'(e_vwena));
      chk("vrf_w_idx",   256'(vrf_w_idx_o),   256'(e_vwidx));
      chk("vrf_w_data",  vrf_w_data_o,        e_vwdata);

      if (e_vwena) vrf[e_vwidx] = e_vwdata;
      if (e_wena)  vram[e_waddr] = e_wdata;
      // Read data only meaningful the cycle after a request; garbage otherwise.
      vmem_r_data_i = vmem_r_ena_o ? vram_rd(vmem_r_addr_o) : rand256();
      vrf_r_data_i  = vrf_r_ena_o  ? vrf[vrf_r_idx_o]       : rand256();
   endtask

   task automatic set_req(input bit v, input bit l, input logic [63:0] a,
                          input logic [4:0] r, input logic [3:0] n);
      req_valid_i = v; req_is_load_i = l; req_addr_i = a; req_vreg_i = r; req_nreg_i = n;
   endtask

   task automatic wait_accept();
      int guard = 0;
      do begin step(); guard++; end while (!acc_flag && guard < 8);
   endtask

   task automatic wait_idle(input bit noise);
      int guard = 0;
      while (m_busy && guard < 40) begin
         if (noise) set_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                            {$urandom(), $urandom()}, 5'($urandom()), 4'($urandom()));
         step();
         guard++;
      end
      req_valid_i = 0;
   endtask

   task automatic run_cmd(input bit l, input logic [63:0] a, input logic [4:0] r,
                          input logic [3:0] n, input bit noise);
      set_req(1, l, a, r, n);
      wait_accept();
      req_valid_i = 0;
      wait_idle(noise);
   endtask

   initial begin
      rst = 0;
      set_req(0, 0, '0, '0, '0);
      vmem_r_data_i = '0;
      vrf_r_data_i  = '0;
      for (int i = 0; i < 32; i++) vrf[i] = rand256();
      @(posedge clk);
      step();
      step();
      rst = 1;
      step();

      // Single-beat load of a known pattern
      vram[64'h1000] = {32{8'hA5}};
      run_cmd(1, 64'h1000, 5'd2, 4'd1, 0);

      // Four-beat store from distinct registers
      for (int i = 0; i < 4; i++) vrf[8 + i] = {32{8'(8'h11 * (i + 1))}};
      run_cmd(0, 64'h2000, 5'd8, 4'd4, 0);

      // Register index and address wrap
      run_cmd(1, 64'h4000, 5'd30, 4'd4, 0);
      run_cmd(1, 64'hFFFF_FFFF_FFFF_FFE0, 5'd3, 4'd2, 0);

      // Out-of-range group sizes
      run_cmd(1, 64'h5000, 5'd7, 4'd0, 0);
      run_cmd(0, 64'h5100, 5'd9, 4'd12, 0);

      // Reset during LD_WB of beat 1 of a four-beat load
      set_req(1, 1, 64'h3000, 5'd6, 4'd4);
      wait_accept();
      req_valid_i = 0;
      while (m_busy && m_t < 4) step();
      rst = 0;
      step();
      rst = 1;
      step();
      run_cmd(0, 64'h3100, 5'd12, 4'd3, 0);

      // Back-to-back with request fields changed mid-command
      set_req(1, 1, 64'h6000, 5'd4, 4'd2);
      wait_accept();
      set_req(1, 0, 64'h7000, 5'd20, 4'd3);
      wait_accept();
      req_valid_i = 0;
      wait_idle(0);

      // Randomized commands with noise on the request port while busy
      for (int k = 0; k < 30; k++) begin
         run_cmd($urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255)))
                                             : {32'h0, $urandom()},
                 5'($urandom()), 4'($urandom_range(0, 15)), 1);
      end
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
